// File: rtl/polybius_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | polybius_pkg : shared constants, mode encoding and helpers for the codec |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package polybius_pkg;

  localparam int unsigned GRID_MAX      = 9;
  localparam logic [7:0]  BASE_CHAR_DEF = 8'h2A;
  localparam logic [7:0]  DIGIT0_DEF    = 8'h31;

  typedef enum logic {
    MODE_DEC = 1'b0,
    MODE_ENC = 1'b1
  } mode_e;

  // Stage-1 payload: the grid index travels together with its own mode.
  typedef struct packed {
    mode_e      mode;
    logic       ok;
    logic [7:0] idx;
  } s1_word_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/polybius_stream_codec_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | polybius_stream_codec_if : valid/ready stream bus and status counters    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface polybius_stream_codec_if;

  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
  logic [15:0] word_cnt;
  logic [15:0] err_cnt;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err, word_cnt, err_cnt
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err, word_cnt, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/polybius_map.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | polybius_map : combinational char <-> grid coordinate mapping            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module polybius_map
  import polybius_pkg::*;
#(
  parameter int unsigned GRID      = 7,
  parameter logic [7:0]  BASE_CHAR = BASE_CHAR_DEF,
  parameter logic [7:0]  DIGIT0    = DIGIT0_DEF
) (
  input  mode_e       i_mode,
  input  logic [15:0] i_data,
  output logic [7:0]  o_idx,
  output logic        o_idx_ok,
  input  mode_e       i_s1_mode,
  input  logic [7:0]  i_s1_idx,
  input  logic        i_s1_ok,
  output logic [15:0] o_data,
  output logic        o_err
);

  localparam logic [7:0] c_grid  = 8'(GRID);
  localparam logic [7:0] c_cells = 8'(GRID * GRID);

  logic [7:0] w_row;
  logic [7:0] w_col;
  logic [7:0] w_key;
  logic       w_dec_ok;
  logic       w_enc_ok;
  logic [7:0] w_quot;
  logic [7:0] w_rem;

  // Subtractions wrap below the base, so one unsigned compare also catches underflow.
  assign w_row    = i_data[15:8] - DIGIT0;
  assign w_col    = i_data[7:0] - DIGIT0;
  assign w_key    = i_data[7:0] - BASE_CHAR;
  assign w_dec_ok = (w_row < c_grid) && (w_col < c_grid);
  assign w_enc_ok = (i_data[7:0] >= BASE_CHAR) && (w_key < c_cells);

  always_comb begin
    o_idx    = 8'h00;
    o_idx_ok = 1'b0;
    if (i_mode == MODE_ENC) begin
      o_idx    = w_key;
      o_idx_ok = w_enc_ok;
    end else begin
      o_idx    = w_row * c_grid + w_col;
      o_idx_ok = w_dec_ok;
    end
  end

  assign w_quot = i_s1_idx / c_grid;
  assign w_rem  = i_s1_idx % c_grid;

  always_comb begin
    o_data = 16'h0000;
    o_err  = 1'b1;
    if (i_s1_ok) begin
      o_err = 1'b0;
      if (i_s1_mode == MODE_ENC) begin
        o_data = {DIGIT0 + w_quot, DIGIT0 + w_rem};
      end else begin
        o_data = {8'h00, BASE_CHAR + i_s1_idx};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/polybius_stream_codec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | polybius_stream_codec : 2-stage valid/ready Polybius encrypt/decrypt     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module polybius_stream_codec
  import polybius_pkg::*;
#(
  parameter int unsigned GRID      = 7,
  parameter logic [7:0]  BASE_CHAR = BASE_CHAR_DEF,
  parameter logic [7:0]  DIGIT0    = DIGIT0_DEF
) (
  input logic                     clk,
  input logic                     rst_n,
  polybius_stream_codec_if.slave  bus
);

  if ((GRID < 2) || (GRID > GRID_MAX) ||
      (32'(BASE_CHAR) + GRID * GRID - 1 > 255) ||
      (32'(DIGIT0) + GRID - 1 > 255)) begin : g_bad_params
    $error("polybius_stream_codec: GRID/BASE_CHAR/DIGIT0 out of 8-bit range");
  end

  logic        r_run;
  logic        r_s1_valid;
  s1_word_t    r_s1_word;
  logic        r_s2_valid;
  logic [15:0] r_s2_data;
  logic        r_s2_err;
  logic [15:0] r_word_cnt;
  logic [15:0] r_err_cnt;

  logic        w_s2_free;
  logic        w_in_ready;
  logic        w_out_fire;
  s1_word_t    w_s1_next;
  logic [15:0] w_map_data;
  logic        w_map_err;

  polybius_map #(
    .GRID      (GRID),
    .BASE_CHAR (BASE_CHAR),
    .DIGIT0    (DIGIT0)
  ) u_map (
    .i_mode    (mode_e'(bus.mode)),
    .i_data    (bus.in_data),
    .o_idx     (w_s1_next.idx),
    .o_idx_ok  (w_s1_next.ok),
    .i_s1_mode (r_s1_word.mode),
    .i_s1_idx  (r_s1_word.idx),
    .i_s1_ok   (r_s1_word.ok),
    .o_data    (w_map_data),
    .o_err     (w_map_err)
  );

  assign w_s1_next.mode = mode_e'(bus.mode);

  // r_run keeps in_ready low during reset and raises it on the first cycle after.
  assign w_s2_free  = !r_s2_valid || bus.out_ready;
  assign w_in_ready = r_run && (!r_s1_valid || w_s2_free);
  assign w_out_fire = r_s2_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_word  <= '{mode: MODE_DEC, ok: 1'b0, idx: 8'h00};
      r_s2_valid <= 1'b0;
      r_s2_data  <= 16'h0000;
      r_s2_err   <= 1'b0;
      r_word_cnt <= 16'h0000;
      r_err_cnt  <= 16'h0000;
    end else begin
      r_run <= 1'b1;
      if (w_in_ready) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_word <= w_s1_next;
        end
      end
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_map_data;
          r_s2_err  <= w_map_err;
        end
      end
      if (w_out_fire) begin
        r_word_cnt <= sat_inc16(r_word_cnt);
        if (r_s2_err) begin
          r_err_cnt <= sat_inc16(r_err_cnt);
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;
  assign bus.out_err   = r_s2_err;
  assign bus.word_cnt  = r_word_cnt;
  assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_polybius_stream_codec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_polybius_stream_codec : scoreboard bench with a table-based model     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_polybius_stream_codec;
  import polybius_pkg::*;

  localparam int         GRID = 7;
  localparam logic [7:0] BASE = 8'h2A;
  localparam logic [7:0] D0   = 8'h31;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  polybius_stream_codec_if bus();

  polybius_stream_codec #(
    .GRID      (GRID),
    .BASE_CHAR (BASE),
    .DIGIT0    (D0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         exp_words = 0;
  int         exp_errs  = 0;
  exp_t       exp_q[$];
  logic [7:0] grid_tab[GRID][GRID];
  int         ready_mode = 0;   // 0 always ready, 1 stalled, 2 random
  bit         stream_active = 1'b0;
  bit         saw_stall     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: search the character table / digit list instead of doing arithmetic.
  function automatic int digit_pos(input logic [7:0] d);
    for (int i = 0; i < GRID; i++) if (int'(D0) + i == int'(d)) return i;
    return -1;
  endfunction

  function automatic exp_t model(input logic m, input logic [15:0] d);
    exp_t e;
    int   r;
    int   c;
    e.data = 16'h0000;
    e.err  = 1'b1;
    if (m == 1'b0) begin
      r = digit_pos(d[15:8]);
      c = digit_pos(d[7:0]);
      if (r >= 0 && c >= 0) begin
        e.data = {8'h00, grid_tab[r][c]};
        e.err  = 1'b0;
      end
    end else begin
      for (int i = 0; i < GRID; i++)
        for (int j = 0; j < GRID; j++)
          if (grid_tab[i][j] == d[7:0]) begin
            e.data = {8'(int'(D0) + i), 8'(int'(D0) + j)};
            e.err  = 1'b0;
          end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: pops the scoreboard on every output transfer and checks held outputs.
  exp_t hold_v;
  bit   hold_p = 1'b0;
  exp_t got_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_p = 1'b0;
    end else begin
      if (stream_active && bus.in_valid && !bus.in_ready) saw_stall = 1'b1;
      if (hold_p)
        check("hold_stable", {15'b0, bus.out_valid, bus.out_err, bus.out_data},
              {15'b0, 1'b1, hold_v.err, hold_v.data});
      hold_p      = bus.out_valid && !bus.out_ready;
      hold_v.data = bus.out_data;
      hold_v.err  = bus.out_err;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: actual data %h err %b, required no output", bus.out_data, bus.out_err);
        end else begin
          got_e = exp_q.pop_front();
          check("out_word", {15'b0, bus.out_err, bus.out_data}, {15'b0, got_e.err, got_e.data});
          exp_words++;
          if (got_e.err) exp_errs++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the transfer edge.
  task automatic send(input logic m, input logic [15:0] d, input bit push, input exp_t e);
    bus.mode     = m;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (n >= 200) begin
        n_checks++;
        $display("FAIL in_ready_timeout: actual 0 after %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic m, input logic [15:0] d);
    send(m, d, 1'b1, model(m, d));
  endtask

  task automatic send_x(input logic m, input logic [15:0] d, input logic [15:0] xd, input logic xe);
    exp_t e;
    e.data = xd;
    e.err  = xe;
    send(m, d, 1'b1, e);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int n = 0; exp_q.size() != 0; n++) begin
      @(posedge clk);
      if (n >= 1000) begin
        n_checks++;
        $display("FAIL drain_timeout: actual %0d words pending, required 0", exp_q.size());
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_word(input logic m);
    if ($urandom_range(0, 1) == 0) return 16'($urandom);
    if (m) return {8'h00, 8'(int'(BASE) + $urandom_range(0, GRID * GRID - 1))};
    return {8'(int'(D0) + $urandom_range(0, GRID - 1)), 8'(int'(D0) + $urandom_range(0, GRID - 1))};
  endfunction

  exp_t       rt_e;
  logic       rm;
  initial begin
    for (int i = 0; i < GRID; i++)
      for (int j = 0; j < GRID; j++)
        grid_tab[i][j] = 8'(int'(BASE) + i * GRID + j);
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, bus.in_ready},  32'd0);
    check("rst_out_data",  {16'b0, bus.out_data},  32'd0);
    check("rst_out_err",   {31'b0, bus.out_err},   32'd0);
    check("rst_word_cnt",  {16'b0, bus.word_cnt},  32'd0);
    check("rst_err_cnt",   {16'b0, bus.err_cnt},   32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Latency: output visible in the second cycle after the transfer
    send_x(1'b0, 16'h3131, 16'h002A, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("latency_cycle1", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("latency_cycle2", {31'b0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Directed corner cases
    send_x(1'b0, 16'h3737, 16'h005A, 1'b0);
    send_x(1'b0, 16'h3831, 16'h0000, 1'b1);
    send_x(1'b0, 16'h3033, 16'h0000, 1'b1);
    send_x(1'b0, 16'h3137, 16'h0030, 1'b0);
    send_x(1'b1, 16'h0041, 16'h3433, 1'b0);
    send_x(1'b1, 16'hFF29, 16'h0000, 1'b1);
    send_x(1'b1, 16'h005A, 16'h3737, 1'b0);
    send_x(1'b1, 16'h005B, 16'h0000, 1'b1);
    send_x(1'b1, 16'h002A, 16'h3131, 1'b0);
    drain();
    check("directed_word_cnt", {16'b0, bus.word_cnt}, 32'd10);
    check("directed_err_cnt",  {16'b0, bus.err_cnt},  32'd4);

    // Back-to-back stream of 10 with a 4-cycle downstream stall, from a clean reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_words = 0;
    exp_errs  = 0;
    @(posedge clk);
    #1;
    stream_active = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rm = 1'($urandom_range(0, 1));
          if (rm) send_m(1'b1, {8'h00, 8'(int'(BASE) + $urandom_range(0, GRID * GRID - 1))});
          else    send_m(1'b0, {8'(int'(D0) + $urandom_range(0, GRID - 1)), 8'(int'(D0) + $urandom_range(0, GRID - 1))});
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int k = 1; k <= 12; k++) begin
          @(posedge clk);
          ready_mode = (k >= 3 && k <= 6) ? 1 : 0;
        end
      end
    join
    stream_active = 1'b0;
    drain();
    check("stream_in_ready_fell", {31'b0, saw_stall}, 32'd1);
    check("stream_word_cnt", {16'b0, bus.word_cnt}, 32'd10);

    // Round trip with mode alternating every word
    ready_mode = 2;
    for (int ch = int'(BASE); ch <= int'(BASE) + GRID * GRID - 1; ch++) begin
      rt_e = model(1'b1, {8'h00, 8'(ch)});
      send_m(1'b1, {8'h00, 8'(ch)});
      send_x(1'b0, rt_e.data, {8'h00, 8'(ch)}, 1'b0);
    end
    drain();

    // Random traffic with gaps and random back-pressure
    for (int i = 0; i < 300; i++) begin
      rm = 1'($urandom_range(0, 1));
      send_m(rm, rand_word(rm));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();
    check("rand_word_cnt", {16'b0, bus.word_cnt}, 32'(exp_words));
    check("rand_err_cnt",  {16'b0, bus.err_cnt},  32'(exp_errs));

    // Reset with two words in flight
    ready_mode = 1;
    @(posedge clk);
    #1;
    send(1'b0, 16'h3131, 1'b0, rt_e);
    send(1'b1, 16'h0041, 1'b0, rt_e);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_in_ready",  {31'b0, bus.in_ready},  32'd0);
    check("midrst_word_cnt",  {16'b0, bus.word_cnt},  32'd0);
    check("midrst_err_cnt",   {16'b0, bus.err_cnt},   32'd0);
    exp_words = 0;
    exp_errs  = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_output", {31'b0, bus.out_valid}, 32'd0);
    end
    check("midrst_final_word_cnt", {16'b0, bus.word_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/polybius_stream_codec.md
POLYBIUS_STREAM_CODEC -- requirements
Module: polybius_stream_codec

Interface
REQ-001 The block SHALL have parameter GRID, default 7, meaning square side; legal range 2..9.
REQ-002 The block SHALL have parameter BASE_CHAR, default 8'h2A ("*"), meaning the character at grid cell (0,0).
REQ-003 The block SHALL have parameter DIGIT0, default 8'h31 ("1"), meaning the ASCII digit for row/column index 0.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning the reset, which is synchronous and active-low.
REQ-006 The block SHALL have port mode, input, 1, meaning 0=decrypt and 1=encrypt, sampled with each accepted input.
REQ-007 The block SHALL have port in_valid, input, 1, meaning the upstream word is valid.
REQ-008 The block SHALL have port in_ready, output, 1, meaning the block can accept a word this cycle.
REQ-009 The block SHALL have port in_data, input, 16, meaning decrypt: [15:8] row digit, [7:0] column digit; encrypt: [7:0] plaintext char, [15:8] ignored.
REQ-010 The block SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-012 The block SHALL have port out_data, output, 16, meaning decrypt: {8'h00, char}; encrypt: {row digit, column digit}.
REQ-013 The block SHALL have port out_err, output, 1, meaning the input was out of range; qualified by out_valid.
REQ-014 The block SHALL have port word_cnt, output, 16, meaning the count of results delivered, saturating at 16'hFFFF.
REQ-015 The block SHALL have port err_cnt, output, 16, meaning the count of delivered results with out_err=1, saturating.

Function
REQ-016 A transfer SHALL occur on an input when in_valid&&in_ready, and on an output when out_valid&&out_ready.
REQ-017 The block SHALL be a 2-stage pipeline: S1 registers the decoded index and mode, S2 registers out_data/out_err; latency from input transfer to out_valid SHALL be 2 cycles with no stall.
REQ-018 Each stage SHALL advance when empty or when the downstream stage advances; in_ready = !S1_valid || S1_advance, so full throughput is 1 word/cycle.
REQ-019 With out_valid=1 and out_ready=0, out_data, out_err and out_valid SHALL hold stable until transfer.
REQ-020 Decrypt: r=in_data[15:8]-DIGIT0 and c=in_data[7:0]-DIGIT0 (8-bit, unsigned); if r<GRID and c<GRID, the output SHALL be BASE_CHAR+r*GRID+c with out_err=0.
REQ-021 Decrypt with either digit outside DIGIT0..DIGIT0+GRID-1, including underflow below DIGIT0, SHALL output 8'h00 in [7:0] with out_err=1.
REQ-022 Encrypt: k=char-BASE_CHAR; if char>=BASE_CHAR and k<GRID*GRID, the output SHALL be {DIGIT0+k/GRID, DIGIT0+k%GRID} with out_err=0.
REQ-023 Encrypt with an out-of-range char SHALL output 16'h0000 with out_err=1.
REQ-024 The index arithmetic SHALL use 8-bit unsigned operations; BASE_CHAR+GRID*GRID-1 SHALL be <= 8'hFF, checked at elaboration.
REQ-025 word_cnt SHALL increment on each output transfer; err_cnt SHALL increment on each output transfer with out_err=1; both SHALL saturate and not wrap.
REQ-026 Mode SHALL travel with its word, so a mode change between consecutive words SHALL NOT affect words already in flight.

Reset
REQ-027 While rst_n=0 at a clock edge, all stage valids, out_valid, out_err, out_data, word_cnt and err_cnt SHALL be 0, and in_ready SHALL be 0.
REQ-028 Reset mid-operation SHALL discard in-flight words without emitting them; in_ready SHALL be 1 on the first cycle after rst_n returns to 1.

Structure
REQ-029 The constants GRID_MAX=9, default BASE_CHAR, default DIGIT0 and the mode encodings (MODE_DEC=0, MODE_ENC=1) SHALL reside in the shared package polybius_pkg.
REQ-030 The combinational char<->coordinate mapping (REQ-020..023) SHALL be one sub-module, polybius_map, free of loops and of table initial blocks.

Verification
REQ-031 Decrypt "1","1" -> out_data 16'h002A, out_err=0, out_valid on the 2nd cycle after transfer.
REQ-032 Decrypt "7","7" -> 8'h5A ("Z"); decrypt "8","1" or "0","3" -> out_err=1, err_cnt increments.
REQ-033 Encrypt "A" (8'h41, k=23) -> 16'h3433 ("43"); encrypt 8'h29 -> out_err=1.
REQ-034 Stream 10 words back-to-back with out_ready held 0 for cycles 3..6 -> no loss or duplication, order kept, in_ready falls when both stages are full, word_cnt=10.
REQ-035 Alternate mode every word, and round-trip every char 8'h2A..8'h5A through encrypt then decrypt -> identity.
REQ-036 Assert rst_n=0 with 2 words in flight -> no output, counters 0, in_ready=1 one cycle after release.
